pe_mac_stream: RTL and testbench
================================

Name: pe_mac_stream

Overview:
- Parametrised systolic-array processing element; successor to the fixed 8-bit always-accumulate PE.
- Adds:
  - valid-qualified operand streams;
  - configurable widths and signedness;
  - tile-length counter that emits a one-cycle `result_vld` pulse and self-clears every K_DEPTH products;
  - explicit `clear`;
  - skew-error detection.
- Instantiated in an R×C grid: north/west feed in, south/east forward to neighbours, and results go to the array drain logic.

Parameters:
- DATA_W, 8: operand width, north and west.
- ACC_W, 32: accumulator/result width; must be ≥ 2*DATA_W.
- K_DEPTH, 16: products per tile before a result is emitted; must be ≥ 1.
- SIGNED, 0: 1 = two's-complement operands (product sign-extended to ACC_W); 0 = unsigned (product zero-extended).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_north  in  DATA_W  operand from north neighbour.
- in_north_vld  in  1  in_north valid.
- in_west  in  DATA_W  operand from west neighbour.
- in_west_vld  in  1  in_west valid.
- clear  in  1  synchronous abort/restart of the current tile.
- out_south  out  DATA_W  registered copy of in_north.
- out_south_vld  out  1  registered in_north_vld.
- out_east  out  DATA_W  registered copy of in_west.
- out_east_vld  out  1  registered in_west_vld.
- result  out  ACC_W  completed tile sum; holds until the next completion.
- result_vld  out  1  one-cycle pulse, result updated this cycle.
- busy  out  1  high while in ACC state.
- skew_err  out  1  sticky: exactly one operand valid was seen.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0, acc=0, cnt=0, state IDLE;
  - takes effect mid-tile with no result emitted.
- Forwarding, every cycle, independent of the FSM:
  - out_south <= in_north, out_south_vld <= in_north_vld;
  - out_east <= in_west, out_east_vld <= in_west_vld;
  - latency 1, and data forwards even when not valid.
- fire = in_north_vld & in_west_vld & ~clear.
- prod: full 2*DATA_W product, extended to ACC_W per SIGNED.
- FSM states:
  - IDLE: cnt=0, acc=0, busy=0. On fire with K_DEPTH>1, acc <= prod, cnt <= 1, go to ACC.
  - ACC: busy=1. On fire, acc <= acc+prod, cnt <= cnt+1. No fire means hold; bubbles are legal.
- Completion, when a fire is the K_DEPTH-th product (cnt==K_DEPTH-1):
  - result <= acc+prod (acc+prod = prod when K_DEPTH=1, which fires from IDLE);
  - result_vld=1 next cycle for exactly one cycle;
  - acc <= 0, cnt <= 0, state IDLE.
  - Back-to-back tiles need no idle cycle: the fire in the cycle after completion starts the next tile.
- clear=1 (priority over fire):
  - acc <= 0, cnt <= 0, state IDLE;
  - result and result_vld unaffected, so no pulse;
  - forwarding unaffected.
- Skew:
  - in_north_vld ^ in_west_vld in any cycle with clear=0 sets skew_err sticky, and no MAC occurs;
  - cleared only by reset;
  - clear itself does not clear it.
- Arithmetic: accumulation wraps modulo 2^ACC_W (without the macro); result is the raw ACC_W value.
- cnt width: $clog2(K_DEPTH+1).

Optional Feature:
- PE_SATURATE_EN defined:
  - accumulation saturates, to 2^ACC_W−1 (unsigned) or to ±(2^(ACC_W−1)) limits (SIGNED=1);
  - extra output port ovf (1 bit) pulses together with result_vld when any add in that tile saturated.
- Not defined: wrap-around arithmetic; no ovf port.

Decomposition:
- Shared package pe_pkg:
  - pe_state_t enum {PE_IDLE, PE_ACC};
  - default localparams PE_DATA_W=8, PE_ACC_W=32, PE_K_DEPTH=16;
  - function ext_prod(prod, signed_mode) for width extension.
- One sub-module pe_mult: combinational DATA_W×DATA_W multiplier honouring SIGNED.
  - Output 2*DATA_W bits.
  - Kept separate so the array can later swap in a pipelined multiplier.

Test Plan:
- Reset/forward: release rst, drive north=0x12/vld=1, west=0x34/vld=1 → next cycle out_south=0x12, out_east=0x34, both vlds=1; all other outputs 0.
- Tile of 4 (K_DEPTH=4): pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles → result=100, result_vld high exactly one cycle, busy falls.
- Bubbles and back-to-back: same pairs with valids low between them → result=100. Next tile (2,2)×4 starts immediately → result=16, two pulses total.
- Clear mid-tile: two fires of (10,10), then clear=1 with valid operands (9,9), then four fires of (1,1) → single result=4; the clear-cycle product is discarded.
- Signed (SIGNED=1, DATA_W=8): (−128,−128),(127,−1) with K_DEPTH=2 → result=16384−127=16257. Skew: north_vld=1, west_vld=0 → skew_err=1 and persists until rst.
- With PE_SATURATE_EN (ACC_W=16, unsigned, K_DEPTH=2): (255,255)×2 → result=0xFFFF, ovf pulses with result_vld. Without the macro → result=0xFC02.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types, default sizes and the product width-extension helper for the
// systolic processing element.
package pe_pkg;

    typedef enum logic {
        PE_IDLE = 1'b0,
        PE_ACC  = 1'b1
    } pe_state_t;

    localparam int PE_DATA_W  = 8;
    localparam int PE_ACC_W   = 32;
    localparam int PE_K_DEPTH = 16;
    // Widest accumulator the helper below can extend into.
    localparam int PE_EXT_W   = 128;

    // Extends the low prod_w bits of prod to PE_EXT_W bits: sign-extended when
    // signed_mode is set, zero-extended otherwise.
    function automatic logic [PE_EXT_W-1:0] ext_prod(
        input logic [PE_EXT_W-1:0] prod,
        input int                  prod_w,
        input logic                signed_mode
    );
        logic [PE_EXT_W-1:0] res;
        logic                fill;
        fill = 1'b0;
        for (int i = 0; i < PE_EXT_W; i++) begin
            if (i == prod_w - 1) begin
                fill = signed_mode & prod[i];
            end
        end
        for (int i = 0; i < PE_EXT_W; i++) begin
            res[i] = (i < prod_w) ? prod[i] : fill;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mult.sv
// Combinational DATA_W x DATA_W multiplier with a full 2*DATA_W result.
// Separate module so a pipelined multiplier can be dropped in later.
module pe_mult #(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] p
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;

    // Extending both operands to 2*DATA_W makes one truncated multiply correct
    // for both two's-complement and unsigned operands.
    generate
        if (SIGNED != 0) begin : g_signed
            assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
            assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin : g_unsigned
            assign a_ext = {{DATA_W{1'b0}}, a};
            assign b_ext = {{DATA_W{1'b0}}, b};
        end
    endgenerate

    assign p = a_ext * b_ext;

endmodule

// File: rtl/pe_mac_stream.sv
// Streaming MAC processing element: forwards operands south/east, sums K_DEPTH
// valid products per tile. Define PE_SATURATE_EN for saturating sums and ovf.
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int DATA_W  = PE_DATA_W,
    parameter int ACC_W   = PE_ACC_W,
    parameter int K_DEPTH = PE_K_DEPTH,
    parameter int SIGNED  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_north,
    input  logic              in_north_vld,
    input  logic [DATA_W-1:0] in_west,
    input  logic              in_west_vld,
    input  logic              clear,
    output logic [DATA_W-1:0] out_south,
    output logic              out_south_vld,
    output logic [DATA_W-1:0] out_east,
    output logic              out_east_vld,
    output logic [ACC_W-1:0]  result,
    output logic              result_vld,
    output logic              busy,
    output logic              skew_err
`ifdef PE_SATURATE_EN
    ,
    output logic              ovf
`endif
);

    localparam int CNT_W = $clog2(K_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_DEPTH - 1);

    pe_state_t         state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ACC_W-1:0]  result_reg, result_next;
    logic              result_vld_reg, result_vld_next;
    logic              skew_reg, skew_next;
    logic [DATA_W-1:0] south_reg, east_reg;
    logic              south_vld_reg, east_vld_reg;

    logic [2*DATA_W-1:0] prod_raw;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    acc_base;
    logic [ACC_W-1:0]    sum_wrap;
    logic [ACC_W-1:0]    sum;
    logic                fire;

    pe_mult #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .a (in_north),
        .b (in_west),
        .p (prod_raw)
    );

    assign prod_ext = ACC_W'(ext_prod(PE_EXT_W'(prod_raw), 2 * DATA_W, SIGNED != 0));
    assign fire     = in_north_vld & in_west_vld & ~clear;
    assign acc_base = (state_reg == PE_ACC) ? acc_reg : '0;
    assign sum_wrap = acc_base + prod_ext;

`ifdef PE_SATURATE_EN
    logic sum_ovf;
    logic tile_ovf_reg, tile_ovf_next;
    logic ovf_reg, ovf_next;

    generate
        if (SIGNED != 0) begin : g_sat_signed
            // Overflow only when both addends share a sign the sum does not.
            assign sum_ovf = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                             (sum_wrap[ACC_W-1] != acc_base[ACC_W-1]);
            assign sum = !sum_ovf ? sum_wrap :
                         acc_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin : g_sat_unsigned
            logic carry;
            logic [ACC_W-1:0] sum_low;
            assign {carry, sum_low} = {1'b0, acc_base} + {1'b0, prod_ext};
            assign sum_ovf = carry;
            assign sum     = carry ? '1 : sum_low;
        end
    endgenerate
`else
    assign sum = sum_wrap;
`endif

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        result_next     = result_reg;
        result_vld_next = 1'b0;
        skew_next       = skew_reg | (~clear & (in_north_vld ^ in_west_vld));
`ifdef PE_SATURATE_EN
        tile_ovf_next   = tile_ovf_reg;
        ovf_next        = 1'b0;
`endif
        if (clear) begin
            state_next = PE_IDLE;
            acc_next   = '0;
            cnt_next   = '0;
`ifdef PE_SATURATE_EN
            tile_ovf_next = 1'b0;
`endif
        end else if (fire) begin
            if (cnt_reg == CNT_LAST) begin
                result_next     = sum;
                result_vld_next = 1'b1;
                state_next      = PE_IDLE;
                acc_next        = '0;
                cnt_next        = '0;
`ifdef PE_SATURATE_EN
                ovf_next      = tile_ovf_reg | sum_ovf;
                tile_ovf_next = 1'b0;
`endif
            end else begin
                state_next = PE_ACC;
                acc_next   = sum;
                cnt_next   = cnt_reg + CNT_W'(1);
`ifdef PE_SATURATE_EN
                tile_ovf_next = tile_ovf_reg | sum_ovf;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= PE_IDLE;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            result_reg     <= '0;
            result_vld_reg <= 1'b0;
            skew_reg       <= 1'b0;
            south_reg      <= '0;
            south_vld_reg  <= 1'b0;
            east_reg       <= '0;
            east_vld_reg   <= 1'b0;
`ifdef PE_SATURATE_EN
            tile_ovf_reg   <= 1'b0;
            ovf_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            result_reg     <= result_next;
            result_vld_reg <= result_vld_next;
            skew_reg       <= skew_next;
            south_reg      <= in_north;
            south_vld_reg  <= in_north_vld;
            east_reg       <= in_west;
            east_vld_reg   <= in_west_vld;
`ifdef PE_SATURATE_EN
            tile_ovf_reg   <= tile_ovf_next;
            ovf_reg        <= ovf_next;
`endif
        end
    end

    assign out_south     = south_reg;
    assign out_south_vld = south_vld_reg;
    assign out_east      = east_reg;
    assign out_east_vld  = east_vld_reg;
    assign result        = result_reg;
    assign result_vld    = result_vld_reg;
    assign busy          = (state_reg == PE_ACC);
    assign skew_err      = skew_reg;
`ifdef PE_SATURATE_EN
    assign ovf           = ovf_reg;
`endif

endmodule

// File: tb/tb_pe_mac_stream.sv
// Bench for pe_mac_stream: three instances (unsigned K=4, signed K=2, 16-bit
// accumulator K=2) share one operand stream, checked against a tile-sum model.
module tb_pe_mac_stream;

    localparam int NI = 3;
    localparam int K_OF  [NI] = '{4, 2, 2};
    localparam bit SG_OF [NI] = '{1'b0, 1'b1, 1'b0};
    localparam int AW_OF [NI] = '{32, 32, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] n, w;
    logic       nv, wv, clr;

    logic [7:0]  south_o [NI];
    logic [7:0]  east_o  [NI];
    logic        south_v [NI];
    logic        east_v  [NI];
    logic [31:0] res_o   [NI];
    logic        vld_o   [NI];
    logic        busy_o  [NI];
    logic        skew_o  [NI];
    logic        ovf_o   [NI];
    logic [15:0] res16;

    assign res_o[2] = {16'd0, res16};

    pe_mac_stream #(.DATA_W(8), .ACC_W(32), .K_DEPTH(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_north(n), .in_north_vld(nv), .in_west(w),
        .in_west_vld(wv), .clear(clr), .out_south(south_o[0]),
        .out_south_vld(south_v[0]), .out_east(east_o[0]), .out_east_vld(east_v[0]),
        .result(res_o[0]), .result_vld(vld_o[0]), .busy(busy_o[0]),
        .skew_err(skew_o[0])
`ifdef PE_SATURATE_EN
        , .ovf(ovf_o[0])
`endif
    );

    pe_mac_stream #(.DATA_W(8), .ACC_W(32), .K_DEPTH(2), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_north(n), .in_north_vld(nv), .in_west(w),
        .in_west_vld(wv), .clear(clr), .out_south(south_o[1]),
        .out_south_vld(south_v[1]), .out_east(east_o[1]), .out_east_vld(east_v[1]),
        .result(res_o[1]), .result_vld(vld_o[1]), .busy(busy_o[1]),
        .skew_err(skew_o[1])
`ifdef PE_SATURATE_EN
        , .ovf(ovf_o[1])
`endif
    );

    pe_mac_stream #(.DATA_W(8), .ACC_W(16), .K_DEPTH(2), .SIGNED(0)) dut_w (
        .clk(clk), .rst(rst), .in_north(n), .in_north_vld(nv), .in_west(w),
        .in_west_vld(wv), .clear(clr), .out_south(south_o[2]),
        .out_south_vld(south_v[2]), .out_east(east_o[2]), .out_east_vld(east_v[2]),
        .result(res16), .result_vld(vld_o[2]), .busy(busy_o[2]),
        .skew_err(skew_o[2])
`ifdef PE_SATURATE_EN
        , .ovf(ovf_o[2])
`endif
    );

`ifndef PE_SATURATE_EN
    assign ovf_o[0] = 1'b0;
    assign ovf_o[1] = 1'b0;
    assign ovf_o[2] = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: running tile sum and product count per instance.
    longint      m_sum [NI];
    int          m_cnt [NI];
    bit          m_tov [NI];
    logic [31:0] m_res [NI];
    bit          m_vld [NI];
    bit          m_ovf [NI];
    bit          m_skew;
    logic [7:0]  m_s, m_e;
    bit          m_sv, m_ev;

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_tov[i] = 0;
            m_res[i] = '0; m_vld[i] = 0; m_ovf[i] = 0;
        end
        m_skew = 0; m_s = '0; m_e = '0; m_sv = 0; m_ev = 0;
    endfunction

    function automatic void model_clock();
        m_s = n; m_sv = nv; m_e = w; m_ev = wv;
        if (!clr && (nv ^ wv)) m_skew = 1;
        for (int i = 0; i < NI; i++) begin
            longint p, s, mask;
            bit o;
            o = 0;
            m_vld[i] = 0;
            m_ovf[i] = 0;
            mask = (longint'(1) << AW_OF[i]) - 1;
            if (clr) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_tov[i] = 0;
            end else if (nv && wv) begin
                if (SG_OF[i]) p = longint'($signed(n)) * longint'($signed(w));
                else          p = longint'(n) * longint'(w);
                s = m_sum[i] + p;
`ifdef PE_SATURATE_EN
                if (SG_OF[i]) begin
                    longint hi, lo;
                    hi = (longint'(1) << (AW_OF[i] - 1)) - 1;
                    lo = -(longint'(1) << (AW_OF[i] - 1));
                    if (s > hi) begin s = hi; o = 1; end
                    if (s < lo) begin s = lo; o = 1; end
                end else if (s > mask) begin
                    s = mask; o = 1;
                end
`else
                s = s & mask;
`endif
                if (m_cnt[i] == K_OF[i] - 1) begin
                    m_res[i] = 32'(s & mask);
                    m_vld[i] = 1;
                    m_ovf[i] = m_tov[i] | o;
                    m_sum[i] = 0; m_cnt[i] = 0; m_tov[i] = 0;
                end else begin
                    m_sum[i] = s;
                    m_cnt[i]++;
                    m_tov[i] |= o;
                end
            end
        end
    endfunction

    task automatic drive(input logic [7:0] dn, input logic [7:0] dw,
                         input logic dnv, input logic dwv, input logic dclr);
        n = dn; w = dw; nv = dnv; wv = dwv; clr = dclr;
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(8'hAA, 8'h55, 1'b1, 1'b1, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({south_o[i], east_o[i], south_v[i], east_v[i], res_o[i], vld_o[i],
                 busy_o[i], skew_o[i]} !== '0)
                $display("FAIL reset_state inst%0d: got res=%0h s=%0h e=%0h busy=%0b skew=%0b required all zero",
                         i, res_o[i], south_o[i], east_o[i], busy_o[i], skew_o[i]);
            if ({south_o[i], east_o[i], south_v[i], east_v[i], res_o[i], vld_o[i],
                 busy_o[i], skew_o[i]} !== '0) errors++;
        end
        rst = 1'b1;
        drive(8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if ({south_o[0], east_o[0], south_v[0], east_v[0]} !== {8'h12, 8'h34, 2'b11}) begin
            errors++;
            $display("FAIL forward: got s=%0h e=%0h sv=%0b ev=%0b required s=12 e=34 sv=1 ev=1",
                     south_o[0], east_o[0], south_v[0], east_v[0]);
        end
        checks++;
        if ({res_o[0], vld_o[0], skew_o[0]} !== '0) begin
            errors++;
            $display("FAIL after_reset_outputs: got res=%0h vld=%0b skew=%0b required 0",
                     res_o[0], vld_o[0], skew_o[0]);
        end
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if (busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle_busy: got %0b required 0", busy_o[0]);
        end
    endtask

    task automatic test_tile();
        int pulses = 0;
        for (int k = 0; k < 4; k++) begin
            drive(8'(2*k + 1), 8'(2*k + 2), 1'b1, 1'b1, 1'b0);
            step();
            checks++;
            if (vld_o[0] !== m_vld[0]) begin
                errors++;
                $display("FAIL tile_vld k=%0d: got %0b required %0b", k, vld_o[0], m_vld[0]);
            end
            if (vld_o[0] === 1'b1) pulses++;
        end
        checks++;
        if (res_o[0] !== 32'd100) begin
            errors++;
            $display("FAIL tile_result: got %0d required 100", res_o[0]);
        end
        drive($urandom, $urandom, 1'b0, 1'b0, 1'b0);
        step();
        if (vld_o[0] === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL tile_pulse: got pulses=%0d busy=%0b required pulses=1 busy=0", pulses, busy_o[0]);
        end
    endtask

    task automatic test_bubbles_b2b();
        int pulses = 0;
        for (int k = 0; k < 4; k++) begin
            drive(8'(2*k + 1), 8'(2*k + 2), 1'b1, 1'b1, 1'b0);
            step();
            if (vld_o[0] === 1'b1) pulses++;
            if (k < 3) begin
                drive($urandom, $urandom, 1'b0, 1'b0, 1'b0);
                step();
                if (vld_o[0] === 1'b1) pulses++;
            end
        end
        checks++;
        if (res_o[0] !== 32'd100 || vld_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL bubble_result: got %0d vld=%0b required 100 vld=1", res_o[0], vld_o[0]);
        end
        for (int k = 0; k < 4; k++) begin
            drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b0);
            step();
            if (vld_o[0] === 1'b1) pulses++;
        end
        checks++;
        if (res_o[0] !== 32'd16 || pulses != 2) begin
            errors++;
            $display("FAIL b2b_result: got %0d pulses=%0d required 16 pulses=2", res_o[0], pulses);
        end
    endtask

    task automatic test_clear();
        int pulses = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 2)       drive(8'd10, 8'd10, 1'b1, 1'b1, 1'b0);
            else if (k == 2) drive(8'd9, 8'd9, 1'b1, 1'b1, 1'b1);
            else             drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
            step();
            if (vld_o[0] === 1'b1) pulses++;
        end
        checks++;
        if (res_o[0] !== 32'd4 || pulses != 1) begin
            errors++;
            $display("FAIL clear_tile: got %0d pulses=%0d required 4 pulses=1", res_o[0], pulses);
        end
    endtask

    task automatic test_signed();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        drive(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
        step();
        drive(8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (res_o[1] !== 32'd16257 || vld_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL signed_result: got %0d vld=%0b required 16257 vld=1", res_o[1], vld_o[1]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        logic        want_ovf;
`ifdef PE_SATURATE_EN
        want = 32'h0000_FFFF; want_ovf = 1'b1;
`else
        want = 32'h0000_FC02; want_ovf = 1'b0;
`endif
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        step();
        step();
        checks++;
        if (res_o[2] !== want || vld_o[2] !== 1'b1 || ovf_o[2] !== want_ovf) begin
            errors++;
            $display("FAIL acc16_result: got %0h vld=%0b ovf=%0b required %0h vld=1 ovf=%0b",
                     res_o[2], vld_o[2], ovf_o[2], want, want_ovf);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            drive($urandom, $urandom, 1'b1, 1'b1, 1'b0);
            step();
        end
        rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({res_o[i], vld_o[i], busy_o[i], south_v[i]} !== '0) begin
                errors++;
                $display("FAIL mid_reset inst%0d: got res=%0h vld=%0b busy=%0b required 0",
                         i, res_o[i], vld_o[i], busy_o[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic both;
            both = ($urandom_range(0, 9) < 8);
            drive($urandom, $urandom, both, both, ($urandom_range(0, 19) == 0));
            step();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({south_o[i], east_o[i], south_v[i], east_v[i]} !== {m_s, m_e, m_sv, m_ev}) begin
                    errors++;
                    $display("FAIL rand_forward c=%0d inst%0d: got %0h/%0h required %0h/%0h",
                             c, i, south_o[i], east_o[i], m_s, m_e);
                end
                checks++;
                if (vld_o[i] !== m_vld[i] || res_o[i] !== m_res[i] || ovf_o[i] !== m_ovf[i]) begin
                    errors++;
                    $display("FAIL rand_result c=%0d inst%0d: got %0h vld=%0b ovf=%0b required %0h vld=%0b ovf=%0b",
                             c, i, res_o[i], vld_o[i], ovf_o[i], m_res[i], m_vld[i], m_ovf[i]);
                end
                checks++;
                if (busy_o[i] !== (m_cnt[i] != 0) || skew_o[i] !== m_skew) begin
                    errors++;
                    $display("FAIL rand_status c=%0d inst%0d: got busy=%0b skew=%0b required busy=%0b skew=%0b",
                             c, i, busy_o[i], skew_o[i], (m_cnt[i] != 0), m_skew);
                end
            end
        end
    endtask

    task automatic test_skew();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if (skew_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL skew_before: got %0b required 0", skew_o[0]);
        end
        drive(8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (skew_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL skew_set: got skew=%0b busy=%0b required skew=1 busy=0", skew_o[0], busy_o[0]);
        end
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        drive(8'h03, 8'h03, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (skew_o[0] !== 1'b1 || skew_o[2] !== m_skew) begin
            errors++;
            $display("FAIL skew_sticky: got %0b required 1", skew_o[0]);
        end
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (skew_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL skew_reset: got %0b required 0", skew_o[0]);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_tile();
        test_bubbles_b2b();
        test_clear();
        test_signed();
        test_wrap();
        test_reset_mid();
        test_random();
        test_skew();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
